mio_clk_div: RTL and testbench
==============================

# mio_clk_div

Synchronous programmable clock divider that consumes the free-running testbench/system clock `clk` and produces a registered divided clock `div_clk` plus a one-cycle `tick` strobe per divided period. The divisor is reprogrammed at run time through a valid/ready port, and changes take effect only on a period boundary, so `div_clk` never glitches. It sits directly downstream of the clock source and feeds slower-clocked agents and DUT stages.

## Interface
Parameters:
- `DIV_W`, 16, width of the divisor and the internal counter.
- `DEFAULT_DIV`, 2, divisor loaded at reset; must be ≥ 2.

Ports:
- `clk`  in  1  source clock; all logic on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `en`  in  1  run request; high = generate, low = stop at the next period boundary.
- `cfg_valid`  in  1  new divisor offered.
- `cfg_div`  in  DIV_W  offered divisor.
- `cfg_ready`  out  1  divider can accept a divisor.
- `cfg_err`  out  1  one-cycle pulse; the divisor accepted in the previous cycle was < 2 and was discarded.
- `div_clk`  out  1  registered divided clock.
- `tick`  out  1  one-cycle pulse coincident with each `div_clk` rising edge.
- `running`  out  1  high in RUN or STOPPING.

## Operation
- States: IDLE, RUN, STOPPING.
- IDLE → RUN when `en`=1. The first edge drives `cnt`=0, `div_clk`=1, `tick`=1.
- RUN → STOPPING when `en`=0.
- STOPPING → RUN when `en`=1. There is no restart; the count continues.
- STOPPING → IDLE at the wrap edge. On that edge: `div_clk`=0, `cnt`=0, `tick`=0.
- Counter: `cnt` runs 0 to `div_q`-1, then wraps to 0. `tick`=1 on every edge that loads `cnt`=0 while the state stays or becomes RUN.
- `div_clk` is registered and equals (next `cnt` < ceil(`div_q`/2)).
  - Period is `div_q` cycles.
  - High time is ceil(`div_q`/2) cycles.
  - Odd divisors are high-biased.
- Config handshake:
  - A transfer occurs when `cfg_valid` && `cfg_ready`.
  - `cfg_ready` = no divisor pending.
  - In IDLE, an accepted value loads `div_q` on the next edge.
  - In RUN or STOPPING, an accepted value is held pending and `cfg_ready` drops. The pending value loads `div_q` at the next wrap edge, and `cfg_ready` rises on that same edge.
  - If a value is accepted in the same cycle as a wrap, it loads at that wrap.
- A divisor < 2 is still handshaken (`cfg_ready` permits the transfer). It is then discarded: `cfg_err` pulses the next cycle, and `div_q` and pending status are unchanged.
- Arithmetic is unsigned, DIV_W bits. Maximum divisor is 2^DIV_W−1. `cnt` never exceeds `div_q`-1.

## Timing
- Reset values: state=IDLE, `cnt`=0, `div_q`=DEFAULT_DIV, pending=0, `div_clk`=0, `tick`=0, `cfg_ready`=1, `cfg_err`=0, `running`=0.
- Start latency: `div_clk` rises 1 cycle after `en` is first sampled high in IDLE.
- Stop latency: after `en` falls, the current period completes. `div_clk` is low and `running`=0 from the wrap edge onward.
- Reset mid-operation: all registers return to reset values on the next edge regardless of state. A pending divisor is lost.
- All outputs are registered. There is no combinational path from input to output except `cfg_ready`, which is pending-state only.

## Structure
- `mio_clk_div_pkg` holds:
  - state enum `mio_clk_div_state_t` (IDLE, RUN, STOPPING);
  - constant `MIO_CLK_DIV_MIN_DIV`=2.
- Sub-module `mio_clk_div_cfg_buf` is a one-deep divisor holding register. It owns `cfg_ready`, the pending flag, the min-divisor check, `cfg_err`, and the load-on-wrap output to the top-level counter/FSM.

## Test plan
- Reset, then `en`=1 with DEFAULT_DIV=2 → `div_clk` toggles 1,0,1,0… starting 1 cycle after `en`; `tick` every 2 cycles.
- Program `cfg_div`=5 in IDLE, then `en`=1 → period 5, high 3 cycles, low 2; `tick` every 5 cycles.
- While running at div=4, offer `cfg_div`=6 at `cnt`=1:
  - `cfg_ready` is low until the wrap;
  - the old period completes at 4;
  - the next period is 6 (high 3).
- Offer `cfg_div`=1 → `cfg_err` pulses once and divisor operation is unchanged.
- Repeat with `cfg_div`=0 → same response.
- At div=8, drop `en` at `cnt`=2:
  - `running` stays high until the wrap;
  - `div_clk` ends low;
  - no extra `tick`.
- Re-raising `en` during STOPPING → period continues uninterrupted.
- Assert `reset_n`=0 mid-period with a divisor pending → all outputs reach reset values on the next edge, and `div_q` is back to 2.

Source files
------------

// File: rtl/mio_clk_div_pkg.sv
// mio_clk_div_pkg
//   Shared types and constants for the programmable clock divider.
//   - mio_clk_div_state_t : divider FSM state (IDLE, RUN, STOPPING)
//   - MIO_CLK_DIV_MIN_DIV : smallest divisor the divider will accept
package mio_clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } mio_clk_div_state_t;

    localparam int unsigned MIO_CLK_DIV_MIN_DIV = 2;

endpackage

// File: rtl/mio_clk_div_cfg_buf.sv
// mio_clk_div_cfg_buf
//   One-deep divisor holding register between the config port and the
//   divider counter. Valid divisors offered while idle load immediately;
//   while running they are parked until the next period wrap so the
//   divided clock never glitches. Divisors below the minimum are still
//   handshaken, then dropped with a one-cycle error pulse.
//
// Ports
//   clk, reset_n     : source clock, synchronous active-low reset
//   cfg_valid        : divisor offered
//   cfg_div          : offered divisor
//   cfg_ready        : no divisor pending (combinational from pending flag)
//   cfg_err          : registered pulse, previous transfer was below minimum
//   is_idle          : divider FSM is in IDLE this cycle
//   wrap             : this edge completes a divided period
//   load_en/load_div : update the active divisor on this edge
//
// Handshake: a transfer happens on any rising edge where cfg_valid and
// cfg_ready are both high; cfg_ready depends only on internal state.
module mio_clk_div_cfg_buf
    import mio_clk_div_pkg::*;
#(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    input  logic             is_idle,
    input  logic             wrap,
    output logic             load_en,
    output logic [DIV_W-1:0] load_div
);

    logic             pending_q, pending_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             cfg_err_q, cfg_err_d;
    logic             xfer;
    logic             div_ok;
    logic             good_xfer;

    always_comb begin
        xfer       = cfg_valid && !pending_q;
        div_ok     = (cfg_div >= DIV_W'(MIO_CLK_DIV_MIN_DIV));
        good_xfer  = xfer && div_ok;
        cfg_err_d  = xfer && !div_ok;
        pending_d  = pending_q;
        pend_div_d = pend_div_q;
        load_en    = 1'b0;
        load_div   = pend_div_q;

        // good_xfer implies nothing is pending, so these branches are exclusive.
        if (good_xfer && (is_idle || wrap)) begin
            load_en  = 1'b1;
            load_div = cfg_div;
        end else if (good_xfer) begin
            pending_d  = 1'b1;
            pend_div_d = cfg_div;
        end else if (pending_q && wrap) begin
            load_en   = 1'b1;
            load_div  = pend_div_q;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_q  <= 1'b0;
            pend_div_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            pend_div_q <= pend_div_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign cfg_ready = !pending_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: rtl/mio_clk_div.sv
// mio_clk_div
//   Programmable clock divider. Produces a registered divided clock with
//   period div_q and high time ceil(div_q/2), plus a tick strobe on each
//   rising edge of div_clk. Stopping always completes the current period.
//
// Ports
//   clk, reset_n : source clock, synchronous active-low reset
//   en           : run request (low = stop at the next period boundary)
//   cfg_valid    : new divisor offered
//   cfg_div      : offered divisor
//   cfg_ready    : divider can accept a divisor
//   cfg_err      : pulse, previously accepted divisor was < 2 and dropped
//   div_clk      : registered divided clock
//   tick         : pulse coincident with each div_clk rising edge
//   running      : FSM in RUN or STOPPING
//   dbg_state    : current FSM state, for observation only
module mio_clk_div
    import mio_clk_div_pkg::*;
#(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               cfg_valid,
    input  logic [DIV_W-1:0]   cfg_div,
    output logic               cfg_ready,
    output logic               cfg_err,
    output logic               div_clk,
    output logic               tick,
    output logic               running,
    output mio_clk_div_state_t dbg_state
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    mio_clk_div_state_t state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               div_clk_q, div_clk_d;
    logic               tick_q, tick_d;
    logic               running_q, running_d;
    logic [DIV_W-1:0]   high_cnt;
    logic               wrap;
    logic               load_en;
    logic [DIV_W-1:0]   load_div;

    mio_clk_div_cfg_buf #(
        .DIV_W (DIV_W)
    ) u_cfg_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .is_idle   (state_q == IDLE),
        .wrap      (wrap),
        .load_en   (load_en),
        .load_div  (load_div)
    );

    // Last count of the current period while the divider is active.
    assign wrap = (state_q != IDLE) && (cnt_q == (div_q - ONE));

    always_comb begin
        // ceil(div_q/2) without widening: odd divisors are high-biased.
        high_cnt  = (div_q >> 1) + {{(DIV_W-1){1'b0}}, div_q[0]};
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = load_en ? load_div : div_q;
        tick_d    = 1'b0;
        div_clk_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    tick_d    = 1'b1;
                    div_clk_d = 1'b1;
                end
            end
            RUN, STOPPING: begin
                state_d = en ? RUN : STOPPING;
                if (wrap) begin
                    cnt_d = '0;
                    if (en) begin
                        tick_d    = 1'b1;
                        div_clk_d = 1'b1;
                    end else begin
                        // Period complete with no run request: park low.
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d     = cnt_q + ONE;
                    div_clk_d = (cnt_d < high_cnt);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        running_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= DIV_W'(DEFAULT_DIV);
            div_clk_q <= 1'b0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            div_clk_q <= div_clk_d;
            tick_q    <= tick_d;
            running_q <= running_d;
        end
    end

    assign div_clk   = div_clk_q;
    assign tick      = tick_q;
    assign running   = running_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mio_clk_div.sv
// tb_mio_clk_div
//   Directed bench for mio_clk_div. Each expected waveform is written out
//   as a string of '0'/'1', one character per source-clock edge, derived
//   by hand from the divisor, high time and start/stop behaviour.
module tb_mio_clk_div;
    import mio_clk_div_pkg::*;

    localparam int unsigned DIV_W = 16;

    logic               clk;
    logic               reset_n;
    logic               en;
    logic               cfg_valid;
    logic [DIV_W-1:0]   cfg_div;
    logic               cfg_ready;
    logic               cfg_err;
    logic               div_clk;
    logic               tick;
    logic               running;
    mio_clk_div_state_t dbg_state;

    int n_vec;
    int n_err;

    mio_clk_div #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .div_clk   (div_clk),
        .tick      (tick),
        .running   (running),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one source edge; sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One step per character; an empty run_s skips the running check.
    task automatic expect_seq(input string tag, input string clk_s, input string tick_s,
                              input string run_s);
        for (int i = 0; i < clk_s.len(); i++) begin
            step();
            check($sformatf("%s[%0d].div_clk", tag, i), {31'd0, div_clk}, {31'd0, clk_s[i] == "1"});
            check($sformatf("%s[%0d].tick", tag, i), {31'd0, tick}, {31'd0, tick_s[i] == "1"});
            if (run_s.len() > 0)
                check($sformatf("%s[%0d].running", tag, i), {31'd0, running}, {31'd0, run_s[i] == "1"});
        end
    endtask

    // Offer a sub-minimum divisor at cnt=0 of a div=6 period.
    task automatic bad_div(input logic [DIV_W-1:0] v);
        cfg_valid = 1'b1;
        cfg_div   = v;
        check($sformatf("bad%0d.ready_pre", v), {31'd0, cfg_ready}, 32'd1);
        step();
        cfg_valid = 1'b0;
        check($sformatf("bad%0d.err_pulse", v), {31'd0, cfg_err}, 32'd1);
        check($sformatf("bad%0d.ready", v), {31'd0, cfg_ready}, 32'd1);
        check($sformatf("bad%0d.clk_cnt1", v), {31'd0, div_clk}, 32'd1);
        step();
        check($sformatf("bad%0d.err_clear", v), {31'd0, cfg_err}, 32'd0);
        check($sformatf("bad%0d.clk_cnt2", v), {31'd0, div_clk}, 32'd1);
        expect_seq($sformatf("bad%0d.div6", v), "0001110001", "0001000001", "1111111111");
        check($sformatf("bad%0d.no_err", v), {31'd0, cfg_err}, 32'd0);
    endtask

    // ---------------- scenario ----------------
    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        step();
        step();
        reset_n = 1'b1;

        // Reset state
        check("rst.div_clk", {31'd0, div_clk}, 32'd0);
        check("rst.tick", {31'd0, tick}, 32'd0);
        check("rst.running", {31'd0, running}, 32'd0);
        check("rst.cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check("rst.cfg_err", {31'd0, cfg_err}, 32'd0);
        check("rst.state", {30'd0, dbg_state}, {30'd0, IDLE});

        // Default divide by 2
        en = 1'b1;
        expect_seq("div2", "101010", "101010", "111111");
        check("div2.state", {30'd0, dbg_state}, {30'd0, RUN});
        en = 1'b0;
        step();
        check("div2.stop_run", {31'd0, running}, 32'd0);
        check("div2.stop_clk", {31'd0, div_clk}, 32'd0);

        // Divide by 5 programmed in IDLE
        cfg_valid = 1'b1;
        cfg_div   = 16'd5;
        check("div5.ready", {31'd0, cfg_ready}, 32'd1);
        step();
        cfg_valid = 1'b0;
        check("div5.ready_after", {31'd0, cfg_ready}, 32'd1);
        en = 1'b1;
        expect_seq("div5", "1110011100", "1000010000", "1111111111");
        en = 1'b0;
        step();
        check("div5.stop_run", {31'd0, running}, 32'd0);

        // Divide by 4, then change to 6 mid-period at cnt=1
        cfg_valid = 1'b1;
        cfg_div   = 16'd4;
        step();
        cfg_valid = 1'b0;
        en = 1'b1;
        expect_seq("div4", "11", "10", "11");
        cfg_valid = 1'b1;
        cfg_div   = 16'd6;
        check("chg.ready_pre", {31'd0, cfg_ready}, 32'd1);
        step();
        cfg_valid = 1'b0;
        check("chg.cnt2_ready", {31'd0, cfg_ready}, 32'd0);
        check("chg.cnt2_clk", {31'd0, div_clk}, 32'd0);
        step();
        check("chg.cnt3_ready", {31'd0, cfg_ready}, 32'd0);
        check("chg.cnt3_clk", {31'd0, div_clk}, 32'd0);
        step();
        check("chg.wrap_ready", {31'd0, cfg_ready}, 32'd1);
        check("chg.wrap_clk", {31'd0, div_clk}, 32'd1);
        check("chg.wrap_tick", {31'd0, tick}, 32'd1);
        expect_seq("div6", "110001", "000001", "111111");

        // Sub-minimum divisors are dropped
        bad_div(16'd1);
        bad_div(16'd0);

        // Move to divide by 8 while running, then stop at cnt=2
        cfg_valid = 1'b1;
        cfg_div   = 16'd8;
        step();
        cfg_valid = 1'b0;
        check("div8.pending", {31'd0, cfg_ready}, 32'd0);
        check("div8.clk_cnt1", {31'd0, div_clk}, 32'd1);
        expect_seq("div8.tail6", "10001", "00001", "11111");
        check("div8.loaded_ready", {31'd0, cfg_ready}, 32'd1);
        expect_seq("div8.head", "11", "00", "11");
        en = 1'b0;
        expect_seq("div8.stop", "1000000", "0000000", "1111100");
        check("div8.stop_state", {30'd0, dbg_state}, {30'd0, IDLE});

        // Re-raise en during STOPPING: period continues
        en = 1'b1;
        expect_seq("resume.head", "111", "100", "111");
        en = 1'b0;
        step();
        check("resume.stopping_clk", {31'd0, div_clk}, 32'd1);
        check("resume.stopping_state", {30'd0, dbg_state}, {30'd0, STOPPING});
        check("resume.stopping_run", {31'd0, running}, 32'd1);
        en = 1'b1;
        expect_seq("resume.tail", "000011", "000010", "111111");

        // Reset mid-period with a divisor pending
        cfg_valid = 1'b1;
        cfg_div   = 16'd3;
        step();
        cfg_valid = 1'b0;
        check("mrst.pending", {31'd0, cfg_ready}, 32'd0);
        step();
        reset_n = 1'b0;
        en      = 1'b0;
        step();
        check("mrst.div_clk", {31'd0, div_clk}, 32'd0);
        check("mrst.tick", {31'd0, tick}, 32'd0);
        check("mrst.running", {31'd0, running}, 32'd0);
        check("mrst.cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check("mrst.cfg_err", {31'd0, cfg_err}, 32'd0);
        reset_n = 1'b1;
        en      = 1'b1;
        expect_seq("mrst.div2", "1010", "1010", "1111");
        en = 1'b0;
        step();
        check("mrst.stop_run", {31'd0, running}, 32'd0);
        check("mrst.stop_clk", {31'd0, div_clk}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
